alu_cmd_issuer: RTL and testbench
=================================

Name: alu_cmd_issuer

Overview:
- Upstream stage of the ALU: buffers ALU command/operand words from a valid/ready producer and issues them to the ALU input pins.
- Spaces issues so each operation has its result window before the next (longer window for multiply commands).
- Buffers in a DEPTH-entry FIFO.
- Outputs connect one-to-one to the ALU's INP_VALID, MODE, CMD, CE, OPA, OPB, CIN pins.

Parameters:
- WIDTH, 8, operand width (OPA/OPB).
- CMD_WIDTH, 4, command field width.
- DEPTH, 8, FIFO entries; power of two, >= 2.
- ISSUE_GAP, 1, idle cycles after a non-multiply issue (0 allowed).
- MUL_GAP, 2, idle cycles after a multiply issue (MODE=1, CMD=9 or 10).

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- en  in  1  issue enable; also drives CE.
- flush  in  1  synchronous FIFO/FSM clear.
- in_valid  in  1  producer has a word.
- in_ready  out  1  FIFO can accept a word.
- in_inp_valid  in  2  operand-valid code for the word.
- in_mode  in  1  1=arithmetic, 0=logical.
- in_cmd  in  CMD_WIDTH  command.
- in_opa  in  WIDTH  operand A.
- in_opb  in  WIDTH  operand B.
- in_cin  in  1  carry in.
- INP_VALID  out  2  to ALU; 00 when not issuing.
- MODE  out  1  to ALU.
- CMD  out  CMD_WIDTH  to ALU.
- CE  out  1  to ALU.
- OPA  out  WIDTH  to ALU.
- OPB  out  WIDTH  to ALU.
- CIN  out  1  to ALU.
- issued  out  1  one-cycle pulse per issue.
- issue_cnt  out  16  total issues, wraps at 65535->0.
- fifo_count  out  $clog2(DEPTH)+1  occupancy.

Behaviour:
- Reset (async assert, sync-clean deassert): FIFO empty, pointers 0, FSM IDLE, gap counter 0. All outputs 0 except in_ready=1.
- Push occurs when in_valid && in_ready. in_ready = !full, registered from occupancy; no push into a full FIFO even if a pop occurs the same cycle.
- Pointers wrap modulo DEPTH. fifo_count is updated on every edge: +1 push only, -1 pop only, unchanged for both or neither.
- A word with in_inp_valid=00 is accepted and issued as-is; the ALU treats it as a no-op. It still uses ISSUE_GAP.
- FSM IDLE:
  - If en && !empty && !flush: pop head. On that edge, register MODE/CMD/OPA/OPB/CIN/INP_VALID from the head.
  - Assert issued=1 and increment issue_cnt.
  - Load gap = MUL_GAP if (mode==1 && cmd in {9,10}) else ISSUE_GAP.
  - Go to WAIT if gap>0, else stay IDLE, allowing back-to-back issue.
- FSM WAIT:
  - INP_VALID=00, issued=0. MODE/CMD/OPA/OPB/CIN hold last issued values.
  - Gap counter decrements each cycle; on reaching 0, next state is IDLE.
  - The gap is not paused by en=0.
- Latency: word pushed at edge t into an empty FIFO with FSM IDLE and en=1 appears on ALU pins after edge t+1 (issued high during cycle t+1..t+2).
- Throughput: one issue per (1+gap) cycles.
- CE = en, registered, reset 0.
- en=0 in IDLE: no pop, INP_VALID=00, FIFO keeps filling.
- flush=1 on an edge:
  - Empties the FIFO, forces IDLE, clears the gap counter, INP_VALID=00.
  - A push in the same cycle is discarded; an issue in the same cycle is suppressed.
  - issue_cnt is not cleared.
- RST mid-WAIT or mid-issue: immediate return to reset values; the in-flight word is lost.

Test Plan:
- Reset then single push (mode=1, cmd=0, opa=8'h05, opb=8'h03, inp_valid=11), en=1 -> INP_VALID=11, OPA=05, OPB=03 exactly 2 edges after push. issued for 1 cycle, then INP_VALID=00 for 1 cycle, issue_cnt=1.
- Push mode=1 cmd=9 then mode=1 cmd=0 back-to-back -> second issue exactly 3 cycles after first (MUL_GAP=2); with ISSUE_GAP=0 build, two non-mul words issue on consecutive cycles.
- en=0, push 9 words -> 8 accepted, in_ready=0 after 8th, fifo_count=8. Set en=1 -> 8 issues in FIFO order, fifo_count returns to 0, in_ready=1 after first pop.
- Fill to 5 entries, assert flush for 1 cycle with in_valid=1 -> fifo_count=0, no issued pulse, the concurrent word is dropped, issue_cnt unchanged.
- Assert RST asynchronously mid-WAIT after a cmd=10 issue -> all outputs 0 immediately without a clock edge. After release, a new push issues normally with no residual gap.
- Preload issue_cnt to 65535 via 65535 issues (or force in sim), then issue one more -> issue_cnt=0.

Source files
------------

// File: rtl/alu_cmd_issuer_if.sv
// Producer-side word interface of the ALU command issuer.
// The producer drives a command/operand word and the issuer answers with in_ready.
interface alu_cmd_issuer_if #(
  parameter int WIDTH     = 8,
  parameter int CMD_WIDTH = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic [1:0]           in_inp_valid;
  logic                 in_mode;
  logic [CMD_WIDTH-1:0] in_cmd;
  logic [WIDTH-1:0]     in_opa;
  logic [WIDTH-1:0]     in_opb;
  logic                 in_cin;

  modport master (
    output in_valid, in_inp_valid, in_mode, in_cmd, in_opa, in_opb, in_cin,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_inp_valid, in_mode, in_cmd, in_opa, in_opb, in_cin,
    output in_ready
  );
endinterface

// File: rtl/alu_cmd_issuer.sv
// ALU command issuer: buffers producer words in a FIFO and drives the ALU
// input pins, leaving an idle window after each issue so the ALU has time to
// produce its result (a longer window for multiplies).
//
// state  | meaning
// S_IDLE | may pop the FIFO head and issue it to the ALU this edge
// S_WAIT | result window of the last issue, gap counter running down
module alu_cmd_issuer #(
  parameter int WIDTH     = 8,
  parameter int CMD_WIDTH = 4,
  parameter int DEPTH     = 8,
  parameter int ISSUE_GAP = 1,
  parameter int MUL_GAP   = 2
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   en,
  input  logic                   flush,
  alu_cmd_issuer_if.slave        bus,
  output logic [1:0]             INP_VALID,
  output logic                   MODE,
  output logic [CMD_WIDTH-1:0]   CMD,
  output logic                   CE,
  output logic [WIDTH-1:0]       OPA,
  output logic [WIDTH-1:0]       OPB,
  output logic                   CIN,
  output logic                   issued,
  output logic [15:0]            issue_cnt,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int AW   = $clog2(DEPTH);
  localparam int MAXG = (MUL_GAP > ISSUE_GAP) ? MUL_GAP : ISSUE_GAP;
  localparam int GW   = (MAXG < 1) ? 1 : $clog2(MAXG + 1);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  typedef struct packed {
    logic [1:0]           iv;
    logic                 mode;
    logic [CMD_WIDTH-1:0] cmd;
    logic [WIDTH-1:0]     opa;
    logic [WIDTH-1:0]     opb;
    logic                 cin;
  } word_t;

  word_t          mem [DEPTH];
  word_t          head;
  word_t          wdata;
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    count;
  logic [AW:0]    count_nxt;
  logic           ready_r;
  logic           push;
  logic           pop;
  logic           head_mul;
  logic [GW-1:0]  gap;
  logic [GW-1:0]  gap_load;
  state_t         state;
  state_t         state_nxt;

  assign wdata      = '{iv: bus.in_inp_valid, mode: bus.in_mode, cmd: bus.in_cmd,
                        opa: bus.in_opa, opb: bus.in_opb, cin: bus.in_cin};
  assign head       = mem[rd_ptr];
  assign push       = bus.in_valid && ready_r && !flush;
  assign head_mul   = head.mode && ((head.cmd == CMD_WIDTH'(9)) || (head.cmd == CMD_WIDTH'(10)));
  assign gap_load   = head_mul ? GW'(MUL_GAP) : GW'(ISSUE_GAP);
  assign bus.in_ready = ready_r;
  assign fifo_count = count;

  // FSM state register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // FSM next state: leave IDLE only when an issue carries a non-zero gap
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (pop && (gap_load != '0)) state_nxt = S_WAIT;
      S_WAIT: if (gap <= GW'(1))           state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (flush) state_nxt = S_IDLE;
  end

  // FSM output decode: pop the head whenever an issue is allowed
  always_comb begin
    pop = 1'b0;
    if ((state == S_IDLE) && en && (count != '0) && !flush) pop = 1'b1;
  end

  // Gap counter: loaded on issue, runs down regardless of en
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)               gap <= '0;
    else if (flush)        gap <= '0;
    else if (pop)          gap <= gap_load;
    else if (gap != '0)    gap <= gap - 1'b1;
  end

  // FIFO storage, written on accepted pushes only
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // Next occupancy; in_ready is derived from it so it is a clean register
  always_comb begin
    count_nxt = count;
    if (push && !pop)      count_nxt = count + 1'b1;
    else if (pop && !push) count_nxt = count - 1'b1;
    if (flush)             count_nxt = '0;
  end

  // FIFO pointers, occupancy and in_ready
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ready_r <= 1'b1;
    end else begin
      count   <= count_nxt;
      ready_r <= (count_nxt != (AW + 1)'(DEPTH));
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // ALU pin registers: fields hold between issues, INP_VALID only during an issue
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      INP_VALID <= '0;
      MODE      <= 1'b0;
      CMD       <= '0;
      CE        <= 1'b0;
      OPA       <= '0;
      OPB       <= '0;
      CIN       <= 1'b0;
      issued    <= 1'b0;
      issue_cnt <= '0;
    end else begin
      CE     <= en;
      issued <= pop;
      if (pop) begin
        INP_VALID <= head.iv;
        MODE      <= head.mode;
        CMD       <= head.cmd;
        OPA       <= head.opa;
        OPB       <= head.opb;
        CIN       <= head.cin;
        issue_cnt <= issue_cnt + 16'd1;
      end else begin
        INP_VALID <= '0;
      end
    end
  end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Testbench for alu_cmd_issuer: directed and random stimulus against a
// cycle-numbered queue model, with a separate monitor scoring every issue.
module tb_alu_cmd_issuer;
  localparam int W  = 8;
  localparam int CW = 4;
  localparam int D  = 8;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic en = 1'b0;
  logic flush = 1'b0;
  always #5 CLK = ~CLK;

  logic [1:0]    INP_VALID;
  logic          MODE, CE, CIN, issued;
  logic [CW-1:0] CMD;
  logic [W-1:0]  OPA, OPB;
  logic [15:0]   issue_cnt;
  logic [3:0]    fifo_count;

  alu_cmd_issuer_if #(.WIDTH(W), .CMD_WIDTH(CW)) bus ();

  alu_cmd_issuer #(.WIDTH(W), .CMD_WIDTH(CW), .DEPTH(D), .ISSUE_GAP(1), .MUL_GAP(2)) dut (
    .CLK(CLK), .RST(RST), .en(en), .flush(flush), .bus(bus),
    .INP_VALID(INP_VALID), .MODE(MODE), .CMD(CMD), .CE(CE), .OPA(OPA), .OPB(OPB),
    .CIN(CIN), .issued(issued), .issue_cnt(issue_cnt), .fifo_count(fifo_count));

  // Second build with no gap after non-multiply issues
  logic rst_z = 1'b1;
  logic en_z = 1'b0;
  logic flush_z = 1'b0;
  logic [1:0]    inp_valid_z;
  logic          mode_z, ce_z, cin_z, issued_z;
  logic [CW-1:0] cmd_z;
  logic [W-1:0]  opa_z, opb_z;
  logic [15:0]   issue_cnt_z;
  logic [3:0]    fifo_count_z;

  alu_cmd_issuer_if #(.WIDTH(W), .CMD_WIDTH(CW)) bus_z ();

  alu_cmd_issuer #(.WIDTH(W), .CMD_WIDTH(CW), .DEPTH(D), .ISSUE_GAP(0), .MUL_GAP(2)) dut_z (
    .CLK(CLK), .RST(rst_z), .en(en_z), .flush(flush_z), .bus(bus_z),
    .INP_VALID(inp_valid_z), .MODE(mode_z), .CMD(cmd_z), .CE(ce_z), .OPA(opa_z), .OPB(opb_z),
    .CIN(cin_z), .issued(issued_z), .issue_cnt(issue_cnt_z), .fifo_count(fifo_count_z));

  typedef struct {
    logic [1:0]    iv;
    logic          mode;
    logic [CW-1:0] cmd;
    logic [W-1:0]  opa;
    logic [W-1:0]  opb;
    logic          cin;
    int            cyc;
    logic [15:0]   cnt;
  } exp_t;

  int n_pass = 0;
  int n_tot  = 0;
  int cyc    = 0;
  bit mon_on = 1'b0;

  exp_t        q[$];
  exp_t        sb[$];
  int          next_ok = 0;
  logic [15:0] m_cnt = '0;
  exp_t        last;
  exp_t        mon_e;

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tot++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
  endfunction

  // One cycle: check state after the edge just passed, then drive and model the next edge.
  task automatic cycle(input bit v, input logic [1:0] iv, input bit mode, input logic [CW-1:0] cmd,
                       input logic [W-1:0] a, input logic [W-1:0] b, input bit cin,
                       input bit e, input bit f);
    exp_t w;
    int   k;
    int   g;
    bit   p;
    bit   po;
    @(posedge CLK);
    #1;
    k = cyc;
    chk("fifo_count", fifo_count, q.size());
    chk("in_ready", bus.in_ready, q.size() < D);
    chk("ce", CE, en);
    p  = v && (q.size() < D) && !f;
    po = e && !f && (q.size() > 0) && (k + 1 >= next_ok);
    if (po) begin
      w = q.pop_front();
      g = (w.mode && (w.cmd == 9 || w.cmd == 10)) ? 2 : 1;
      next_ok = k + 2 + g;
      m_cnt = m_cnt + 16'd1;
      w.cyc = k + 1;
      w.cnt = m_cnt;
      sb.push_back(w);
    end
    if (p) begin
      w.iv = iv; w.mode = mode; w.cmd = cmd; w.opa = a; w.opb = b; w.cin = cin;
      w.cyc = 0; w.cnt = '0;
      q.push_back(w);
    end
    if (f) begin
      q.delete();
      next_ok = k + 2;
    end
    bus.in_valid = v; bus.in_inp_valid = iv; bus.in_mode = mode; bus.in_cmd = cmd;
    bus.in_opa = a; bus.in_opb = b; bus.in_cin = cin;
    en = e; flush = f;
  endtask

  task automatic idle(input bit e, input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 2'b00, 1'b0, '0, '0, '0, 1'b0, e, 1'b0);
  endtask

  // Monitor: every issue pops the scoreboard; between issues the pins must idle and hold
  always @(negedge CLK) begin
    if (RST) begin
      last = '{default: '0};
    end else if (mon_on) begin
      if (issued) begin
        if (sb.size() == 0) begin
          chk("unexpected_issue", 1, 0);
        end else begin
          mon_e = sb.pop_front();
          chk("issue_cycle", cyc, mon_e.cyc);
          chk("issue_word", {INP_VALID, MODE, CMD, OPA, OPB, CIN},
              {mon_e.iv, mon_e.mode, mon_e.cmd, mon_e.opa, mon_e.opb, mon_e.cin});
          chk("issue_cnt", issue_cnt, mon_e.cnt);
          last = mon_e;
        end
      end else begin
        if (sb.size() > 0 && sb[0].cyc <= cyc) begin
          chk("missed_issue", 0, 1);
          sb.delete(0);
        end
        chk("idle_inp_valid", INP_VALID, 0);
        chk("hold_fields", {MODE, CMD, OPA, OPB, CIN}, {last.mode, last.cmd, last.opa, last.opb, last.cin});
      end
    end
  end

  task automatic main_test();
    bus.in_valid = 0; bus.in_inp_valid = 0; bus.in_mode = 0; bus.in_cmd = 0;
    bus.in_opa = 0; bus.in_opb = 0; bus.in_cin = 0;
    repeat (3) @(posedge CLK);
    #2 RST = 1'b0;
    mon_on = 1'b1;
    #1;
    chk("reset_outputs", {INP_VALID, MODE, CMD, CE, OPA, OPB, CIN, issued, issue_cnt, fifo_count}, 0);
    chk("reset_in_ready", bus.in_ready, 1);

    // single word, then multiply followed by a plain word
    cycle(1, 2'b11, 1, 4'd0, 8'h05, 8'h03, 0, 1, 0);
    idle(1, 4);
    cycle(1, 2'b11, 1, 4'd9, 8'h12, 8'h34, 1, 1, 0);
    cycle(1, 2'b11, 1, 4'd0, 8'h56, 8'h78, 0, 1, 0);
    cycle(1, 2'b00, 0, 4'd3, 8'h9A, 8'hBC, 1, 1, 0);
    idle(1, 8);

    // fill with issue disabled, overflow attempt, then drain in order
    for (int i = 0; i < 9; i++)
      cycle(1, 2'b10, 0, CW'(i), W'(i * 17), W'(255 - i), i[0], 0, 0);
    idle(0, 2);
    idle(1, 20);

    // flush with a concurrent push and issue enabled
    for (int i = 0; i < 5; i++)
      cycle(1, 2'b01, 1, 4'd10, W'(i), W'(i + 1), 0, 0, 0);
    cycle(1, 2'b11, 0, 4'd1, 8'hEE, 8'hDD, 1, 1, 1);
    idle(0, 2);
    idle(1, 3);
    cycle(1, 2'b11, 0, 4'd2, 8'h21, 8'h43, 0, 1, 0);
    idle(1, 4);

    // randomized traffic with a bias toward multiply commands
    for (int i = 0; i < 1500; i++) begin
      logic [CW-1:0] c;
      int sel;
      sel = $urandom_range(0, 3);
      c = (sel == 0) ? CW'(9) : (sel == 1) ? CW'(10) : CW'($urandom_range(0, 15));
      cycle($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), c,
            W'($urandom), W'($urandom), 1'($urandom_range(0, 1)),
            $urandom_range(0, 7) != 0, $urandom_range(0, 63) == 0);
    end
    idle(1, 30);
    chk("scoreboard_drained", sb.size(), 0);

    // async reset during the multiply window
    cycle(1, 2'b11, 1, 4'd10, 8'hAA, 8'h55, 1, 1, 0);
    idle(1, 3);
    #2 RST = 1'b1;
    #1;
    chk("async_reset_outputs", {INP_VALID, MODE, CMD, CE, OPA, OPB, CIN, issued, issue_cnt, fifo_count}, 0);
    chk("async_reset_in_ready", bus.in_ready, 1);
    q.delete(); sb.delete(); next_ok = 0; m_cnt = '0;
    repeat (2) @(posedge CLK);
    #2 RST = 1'b0;
    cycle(1, 2'b11, 0, 4'd4, 8'h0F, 8'hF0, 0, 1, 0);
    cycle(1, 2'b01, 0, 4'd5, 8'h11, 8'h22, 1, 1, 0);
    idle(1, 6);
    chk("post_reset_drained", sb.size(), 0);
  endtask

  task automatic wrap_test();
    int n = 0;
    int t1 = 0;
    bit prev = 1'b0;
    bus_z.in_valid = 0; bus_z.in_inp_valid = 2'b01; bus_z.in_mode = 0; bus_z.in_cmd = 4'd1;
    bus_z.in_opa = 8'h3C; bus_z.in_opb = 8'hC3; bus_z.in_cin = 0;
    repeat (2) @(posedge CLK);
    #2 rst_z = 1'b0;
    en_z = 1'b1;
    bus_z.in_valid = 1'b1;
    for (int t = 0; t < 70000 && n < 65536; t++) begin
      @(negedge CLK);
      if (issued_z) begin
        n++;
        if (n == 1) begin
          t1 = t;
          chk("gap0_first_cnt", issue_cnt_z, 1);
          chk("gap0_first_word", {inp_valid_z, mode_z, cmd_z, opa_z, opb_z, cin_z},
              {2'b01, 1'b0, 4'd1, 8'h3C, 8'hC3, 1'b0});
        end
        if (n == 2) chk("gap0_back_to_back", prev, 1);
        if (n == 65535) chk("cnt_max", issue_cnt_z, 16'hFFFF);
        if (n == 65536) begin
          chk("cnt_wrap", issue_cnt_z, 0);
          chk("gap0_throughput", t - t1, 65535);
        end
      end
      prev = issued_z;
    end
    if (n < 65536) chk("wrap_timeout", n, 65536);
  endtask

  initial begin
    fork
      main_test();
      wrap_test();
    join
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
